// File: rtl/aes_key_sched.sv
`default_nettype none
// ============================================================================
// aes_key_sched : iterative AES-128/192/256 key schedule, one word per step,
//                 streaming NR+1 round keys over a valid/ready interface.
// Rev 1.0
// ============================================================================

module aes_key_sched_s4 (
    input  logic        clk,
    input  logic [31:0] in_i,
    output logic [31:0] out_o
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Inverse as x^254 by square-and-multiply, then the AES affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] t;
        logic [7:0] r;
        t = x;
        r = 8'h01;
        for (int k = 1; k < 8; k++) begin
            t = gf_mul(t, t);
            r = gf_mul(r, t);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]}
                 ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    logic [31:0] out_q;

    always_ff @(posedge clk) begin
        out_q <= {sbox(in_i[31:24]), sbox(in_i[23:16]), sbox(in_i[15:8]), sbox(in_i[7:0])};
    end

    assign out_o = out_q;

endmodule

module aes_key_sched #(
    parameter int KEY_LEN = 128
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic [KEY_LEN-1:0] key_i,
    output logic               busy_o,
    output logic               rk_valid_o,
    input  logic               rk_ready_i,
    output logic [127:0]       rk_data_o,
    output logic [3:0]         rk_idx_o,
    output logic               rk_last_o
);

    localparam int         NK        = KEY_LEN / 32;
    localparam int         NR        = NK + 6;
    localparam logic [5:0] I_KEY_END = 6'(NK - 1);
    localparam logic [5:0] I_END     = 6'(4 * NR + 3);
    localparam logic [2:0] J_END     = 3'(NK - 1);
    localparam logic [3:0] IDX_LAST  = 4'(NR);

    if (KEY_LEN != 128 && KEY_LEN != 192 && KEY_LEN != 256) begin : g_bad_key_len
        $error("aes_key_sched: KEY_LEN must be 128, 192 or 256");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SUB  = 2'd2,
        WR   = 2'd3
    } state_t;

    state_t             state_q;
    logic [KEY_LEN-1:0] win_q;
    logic [95:0]        asm_q;
    logic [1:0]         cnt_q;
    logic [5:0]         i_q;
    logic [2:0]         j_q;
    logic [7:0]         rcon_q;
    logic               busy_q;
    logic               rk_valid_q;
    logic               rk_last_q;
    logic [127:0]       rk_data_q;
    logic [3:0]         rk_idx_q;

    logic [31:0] w_old;
    logic [31:0] w_prev;
    logic [31:0] s4_in;
    logic [31:0] s4_out;
    logic [31:0] temp_d;
    logic [31:0] word_d;
    logic [7:0]  rcon_d;
    logic        rot_sel;
    logic        sub_sel;
    logic        grp_full;
    logic        can_append;
    logic        fire;
    logic        accept;

    // Window holds w[i-Nk] (top) .. w[i-1] (bottom); LOAD rotates it so it
    // ends up holding the key again when generation starts.
    assign w_old      = win_q[KEY_LEN-1 -: 32];
    assign w_prev     = win_q[31:0];
    assign rot_sel    = (j_q == 3'd0);
    assign sub_sel    = (NK == 8) && (j_q == 3'd4);
    assign s4_in      = rot_sel ? {w_prev[23:0], w_prev[31:24]} : w_prev;
    assign temp_d     = rot_sel ? (s4_out ^ {rcon_q, 24'h0}) : (sub_sel ? s4_out : w_prev);
    assign word_d     = (state_q == LOAD) ? w_old : (w_old ^ temp_d);
    assign rcon_d     = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
    assign grp_full   = (cnt_q == 2'd3);
    assign can_append = !grp_full || !rk_valid_q || rk_ready_i;
    assign fire       = ((state_q == LOAD) || (state_q == WR)) && can_append;
    assign accept     = rk_valid_q && rk_ready_i;

    aes_key_sched_s4 u_s4 (
        .clk   (clk),
        .in_i  (s4_in),
        .out_o (s4_out)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            win_q      <= '0;
            asm_q      <= '0;
            cnt_q      <= 2'd0;
            i_q        <= 6'd0;
            j_q        <= 3'd0;
            rcon_q     <= 8'h01;
            busy_q     <= 1'b0;
            rk_valid_q <= 1'b0;
            rk_last_q  <= 1'b0;
            rk_data_q  <= '0;
            rk_idx_q   <= 4'd0;
        end else begin
            if (accept) begin
                rk_valid_q <= 1'b0;
                rk_last_q  <= 1'b0;
                if (rk_last_q) busy_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (start_i && !busy_q) begin
                        state_q <= LOAD;
                        win_q   <= key_i;
                        cnt_q   <= 2'd0;
                        i_q     <= 6'd0;
                        j_q     <= 3'd0;
                        rcon_q  <= 8'h01;
                        busy_q  <= 1'b1;
                    end
                end
                SUB: state_q <= WR;
                default: begin
                    if (fire) begin
                        win_q <= {win_q[KEY_LEN-33:0], word_d};
                        if (grp_full) begin
                            rk_data_q  <= {asm_q, word_d};
                            rk_idx_q   <= i_q[5:2];
                            rk_last_q  <= (i_q[5:2] == IDX_LAST);
                            rk_valid_q <= 1'b1;
                            cnt_q      <= 2'd0;
                        end else begin
                            asm_q <= {asm_q[63:0], word_d};
                            cnt_q <= cnt_q + 2'd1;
                        end
                        i_q <= i_q + 6'd1;
                        j_q <= (j_q == J_END) ? 3'd0 : j_q + 3'd1;
                        if (state_q == WR && rot_sel) rcon_q <= rcon_d;
                        if (state_q == LOAD)
                            state_q <= (i_q == I_KEY_END) ? SUB : LOAD;
                        else
                            state_q <= (i_q == I_END) ? IDLE : SUB;
                    end
                end
            endcase
        end
    end

    assign busy_o     = busy_q;
    assign rk_valid_o = rk_valid_q;
    assign rk_data_o  = rk_data_q;
    assign rk_idx_o   = rk_idx_q;
    assign rk_last_o  = rk_last_q;

endmodule

`default_nettype wire

// File: tb/tb_aes_key_sched.sv
`default_nettype none
// ============================================================================
// tb_aes_key_sched : directed FIPS-197 vectors for all three key sizes.
// Rev 1.0
// ============================================================================

module tb_aes_key_sched;

    localparam logic [127:0] K128  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [191:0] K192  = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
    localparam logic [255:0] K256  = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam int           LIMIT = 1000;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         rk_ready;
    logic [1:0]   sel;
    logic [127:0] key128;
    logic [191:0] key192;
    logic [255:0] key256;

    logic         busy_a, valid_a, last_a;
    logic         busy_b, valid_b, last_b;
    logic         busy_c, valid_c, last_c;
    logic [127:0] data_a, data_b, data_c;
    logic [3:0]   idx_a, idx_b, idx_c;

    logic         m_busy, m_valid, m_last;
    logic [127:0] m_data;
    logic [3:0]   m_idx;

    logic [127:0] exp128 [11];
    logic [127:0] got_data [16];
    int           got_idx [16];
    logic         got_last [16];
    int           appear [16];
    int           n_got, n_seen, busy_fall;
    int           n_chk, n_fail;

    aes_key_sched #(.KEY_LEN(128)) u_dut128 (
        .clk(clk), .rst_n(rst_n), .start_i(start && sel == 2'd0), .key_i(key128),
        .busy_o(busy_a), .rk_valid_o(valid_a), .rk_ready_i(rk_ready),
        .rk_data_o(data_a), .rk_idx_o(idx_a), .rk_last_o(last_a)
    );

    aes_key_sched #(.KEY_LEN(192)) u_dut192 (
        .clk(clk), .rst_n(rst_n), .start_i(start && sel == 2'd1), .key_i(key192),
        .busy_o(busy_b), .rk_valid_o(valid_b), .rk_ready_i(rk_ready),
        .rk_data_o(data_b), .rk_idx_o(idx_b), .rk_last_o(last_b)
    );

    aes_key_sched #(.KEY_LEN(256)) u_dut256 (
        .clk(clk), .rst_n(rst_n), .start_i(start && sel == 2'd2), .key_i(key256),
        .busy_o(busy_c), .rk_valid_o(valid_c), .rk_ready_i(rk_ready),
        .rk_data_o(data_c), .rk_idx_o(idx_c), .rk_last_o(last_c)
    );

    always_comb begin
        m_busy  = busy_a;
        m_valid = valid_a;
        m_last  = last_a;
        m_data  = data_a;
        m_idx   = idx_a;
        case (sel)
            2'd1: begin
                m_busy = busy_b; m_valid = valid_b; m_last = last_b; m_data = data_b; m_idx = idx_b;
            end
            2'd2: begin
                m_busy = busy_c; m_valid = valid_c; m_last = last_c; m_data = data_c; m_idx = idx_c;
            end
            default: ;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Starts a run on the selected instance and consumes beats at negedges.
    // Stops when busy drops, when abort_n beats have been taken, or on timeout.
    task automatic run(input int pct, input int abort_n, input bit inject);
        int           k;
        bit           held;
        logic [127:0] h_data;
        logic [3:0]   h_idx;
        n_got = 0; n_seen = 0; busy_fall = -1; held = 1'b0;
        h_data = '0; h_idx = '0;
        for (int b = 0; b < 16; b++) appear[b] = -1;
        start = 1'b1;
        @(posedge clk);
        k = 0;
        forever begin
            @(negedge clk);
            start = 1'b0;
            if (abort_n >= 0 && n_got == abort_n) break;
            if (!m_busy) begin
                busy_fall = k;
                break;
            end
            if (held) begin
                check("hold valid", m_valid, 1'b1);
                check("hold data", m_data, h_data);
                check("hold idx", m_idx, h_idx);
            end else if (m_valid) begin
                if (n_seen < 16) appear[n_seen] = k;
                n_seen++;
            end
            rk_ready = ($urandom_range(99) < pct);
            if (m_valid && rk_ready) begin
                if (n_got < 16) begin
                    got_data[n_got] = m_data;
                    got_idx[n_got]  = int'(m_idx);
                    got_last[n_got] = m_last;
                end
                n_got++;
                if (inject && m_last) start = 1'b1;
            end
            held   = m_valid && !rk_ready;
            h_data = m_data;
            h_idx  = m_idx;
            if (inject && k == 19) begin
                start  = 1'b1;
                key128 = ~K128;
            end
            k++;
            if (k > LIMIT) begin
                check("run timeout busy", m_busy, 1'b0);
                break;
            end
        end
        rk_ready = 1'b1;
    endtask

    task automatic check_seq128(input string nm);
        check($sformatf("%s beat count", nm), n_got, 11);
        for (int b = 0; b < 11; b++) begin
            check($sformatf("%s rk%0d data", nm, b), got_data[b], exp128[b]);
            check($sformatf("%s rk%0d idx", nm, b), got_idx[b], b);
            check($sformatf("%s rk%0d last", nm, b), got_last[b], b == 10);
        end
    endtask

    initial begin
        exp128[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        exp128[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        exp128[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        exp128[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        exp128[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        exp128[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        exp128[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        exp128[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        exp128[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        exp128[9]  = 128'hac7766f319fadc2128d12941575c006e;
        exp128[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        n_chk = 0; n_fail = 0;
        rst_n = 1'b0; start = 1'b0; rk_ready = 1'b1; sel = 2'd0;
        key128 = K128; key192 = K192; key256 = K256;

        repeat (2) @(negedge clk);
        check("reset busy", m_busy, 1'b0);
        check("reset valid", m_valid, 1'b0);
        check("reset last", m_last, 1'b0);
        check("reset data", m_data, 128'h0);
        check("reset idx", m_idx, 4'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // AES-128, full rate, start pulses at E20 and on the final accept
        run(100, -1, 1'b1);
        check_seq128("k128");
        check("k128 rk0 time", appear[0], 4);
        check("k128 rk1 time", appear[1], 12);
        check("k128 rk10 time", appear[10], 84);
        check("k128 busy fall", busy_fall, 85);
        @(negedge clk);
        check("ignored start busy", m_busy, 1'b0);
        check("ignored start valid", m_valid, 1'b0);

        // AES-128 with back-pressure
        key128 = K128;
        run(30, -1, 1'b0);
        check_seq128("bp128");

        // Reset during rk5 generation, then a fresh run
        run(100, 5, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst busy", m_busy, 1'b0);
        check("midrst valid", m_valid, 1'b0);
        check("midrst last", m_last, 1'b0);
        check("midrst data", m_data, 128'h0);
        check("midrst idx", m_idx, 4'h0);
        rst_n = 1'b1;
        @(negedge clk);
        run(100, -1, 1'b0);
        check_seq128("rerun128");
        check("rerun128 rk10 time", appear[10], 84);

        // AES-192
        sel = 2'd1;
        run(100, -1, 1'b0);
        check("k192 beat count", n_got, 13);
        check("k192 rk0 data", got_data[0], 128'h8e73b0f7da0e6452c810f32b809079e5);
        check("k192 rk1 time", appear[1], 10);
        check("k192 rk12 data", got_data[12], 128'he98ba06f448c773c8ecc720401002202);
        check("k192 rk12 idx", got_idx[12], 12);
        check("k192 rk12 last", got_last[12], 1'b1);
        check("k192 rk12 time", appear[12], 98);

        // AES-256
        sel = 2'd2;
        run(100, -1, 1'b0);
        check("k256 beat count", n_got, 15);
        check("k256 rk1 data", got_data[1], 128'h1f352c073b6108d72d9810a30914dff4);
        check("k256 rk1 time", appear[1], 8);
        check("k256 rk2 time", appear[2], 16);
        check("k256 rk14 data", got_data[14], 128'hfe4890d1e6188d0b046df344706c631e);
        check("k256 rk14 idx", got_idx[14], 14);
        check("k256 rk14 last", got_last[14], 1'b1);
        check("k256 rk14 time", appear[14], 112);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
